sipo_deserializer: RTL and testbench

Serial-in, parallel-out deserializer. It is the receiving end of the team's parallel-load shift register: it collects a qualified serial bit stream into WIDTH-bit words and presents each completed word on a parallel output with a one-cycle valid strobe. It sits on the receive side of any serial link driven by our shift-register transmitter, and supports matching shift direction and optional parity.

---
 rtl/sipo_pkg.sv | 24 ++
 rtl/sipo_bit_counter.sv | 41 ++++
 rtl/sipo_deserializer.sv | 130 +++++++++++++
 tb/tb_sipo_deserializer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in, parallel-out deserializer.
// Holds the shift-direction names, the receive FSM state encoding and the
// even-parity helper used when SIPO_DESERIALIZER_PARITY_EN is defined.
package sipo_pkg;

  // Accepted values of the SHIFT_DIRECTION parameter
  localparam string DIR_RIGHT = "RIGHT";  // LSB-first: new bit enters at the MSB
  localparam string DIR_LEFT  = "LEFT";   // MSB-first: new bit enters at the LSB

  // Receive FSM state; PAR is only reachable when the parity bit is enabled
  typedef logic [0:0] state_t;
  localparam state_t ST_DATA = 1'b0;
  localparam state_t ST_PAR  = 1'b1;

  // Widest data word the parity helper folds; zero-extension leaves XOR unchanged
  localparam int PARITY_MAX_W = 64;

  // Even parity check: returns 1 when data plus parity bit has odd weight
  function automatic logic parity_mismatch(input logic [PARITY_MAX_W-1:0] data,
                                           input logic                    pbit);
    return (^data) ^ pbit;
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Modulo-WIDTH bit counter for the deserializer.
// Counts accepted data bits; tc is high while the counter sits on the last
// bit position, so the next inc completes a word and wraps the count to 0.
module sipo_bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic tc
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  assign tc = (cnt_reg == LAST);

  // Next count: clear wins over increment; wrap explicitly so non-power-of-2 widths work
  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (inc) begin
      cnt_next = tc ? '0 : cnt_reg + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out deserializer.
// Collects qualified serial bits into WIDTH-bit words and presents each
// completed word on PO with a one-cycle po_valid strobe.
// Optional feature macro: SIPO_DESERIALIZER_PARITY_EN -- when defined, each
// frame carries one trailing even-parity bit and parity_err reports mismatches
// (parity_err supports WIDTH up to 64); when undefined, parity_err is tied low.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int    WIDTH           = 8,
  parameter string SHIFT_DIRECTION = "RIGHT"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  input  logic             si_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] PO,
  output logic             po_valid,
  output logic             parity_err
);

  localparam bit SHIFT_LEFT = (SHIFT_DIRECTION == DIR_LEFT);

  logic [WIDTH-1:0] sr_reg;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] po_reg;
  logic             po_valid_reg;
  logic             last_bit;
  logic             cnt_inc;

  // Shifted value if the current si is accepted, built one bit per lane
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (SHIFT_LEFT) begin : g_left
        if (gi == 0) begin : g_entry
          assign sr_next[gi] = si;
        end else begin : g_move
          assign sr_next[gi] = sr_reg[gi-1];
        end
      end else begin : g_right
        if (gi == WIDTH - 1) begin : g_entry
          assign sr_next[gi] = si;
        end else begin : g_move
          assign sr_next[gi] = sr_reg[gi+1];
        end
      end
    end
  endgenerate

`ifdef SIPO_DESERIALIZER_PARITY_EN
  state_t state_reg;
  logic   parity_err_reg;

  // Data bits are only counted in DATA; the parity bit does not advance the counter
  assign cnt_inc = si_valid && (state_reg == ST_DATA);

  // Shift register, FSM and output registers; priority rst > clear > si_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_reg         <= '0;
      state_reg      <= ST_DATA;
      po_reg         <= '0;
      po_valid_reg   <= 1'b0;
      parity_err_reg <= 1'b0;
    end else if (clear) begin
      sr_reg       <= '0;
      state_reg    <= ST_DATA;
      po_valid_reg <= 1'b0;
    end else if (si_valid) begin
      if (state_reg == ST_PAR) begin
        po_reg         <= sr_reg;
        parity_err_reg <= parity_mismatch(PARITY_MAX_W'(sr_reg), si);
        po_valid_reg   <= 1'b1;
        state_reg      <= ST_DATA;
      end else begin
        sr_reg       <= sr_next;
        po_valid_reg <= 1'b0;
        if (last_bit) begin
          state_reg <= ST_PAR;
        end
      end
    end else begin
      po_valid_reg <= 1'b0;
    end
  end

  assign parity_err = parity_err_reg;
`else
  // Every accepted bit is a data bit
  assign cnt_inc = si_valid;

  // Shift register and output registers; priority rst > clear > si_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_reg       <= '0;
      po_reg       <= '0;
      po_valid_reg <= 1'b0;
    end else if (clear) begin
      sr_reg       <= '0;
      po_valid_reg <= 1'b0;
    end else if (si_valid) begin
      sr_reg       <= sr_next;
      po_valid_reg <= last_bit;
      if (last_bit) begin
        po_reg <= sr_next;
      end
    end else begin
      po_valid_reg <= 1'b0;
    end
  end

  assign parity_err = 1'b0;
`endif

  sipo_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk (clk),
    .rst (rst),
    .inc (cnt_inc),
    .clr (clear),
    .tc  (last_bit)
  );

  assign PO       = po_reg;
  assign po_valid = po_valid_reg;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer: one serial stream drives a RIGHT
// (LSB-first) and a LEFT (MSB-first) instance. A frame-level model collects
// accepted bits, pushes the expected word for each instance when a frame
// completes, and a negedge monitor checks every cycle against the queues.
// Build with +define+SIPO_DESERIALIZER_PARITY_EN to exercise the parity frame.
module tb_sipo_deserializer;

  localparam int W = 8;
`ifdef SIPO_DESERIALIZER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  typedef struct {
    logic [W-1:0] word;
    logic         perr;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         si = 1'b0;
  logic         si_valid = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] po_r, po_l;
  logic         pv_r, pv_l, pe_r, pe_l;

  exp_t         q_r[$];
  exp_t         q_l[$];
  bit           bits_q[$];
  logic [W-1:0] held_r = '0;
  logic [W-1:0] held_l = '0;
  logic         held_pe_r = 1'b0;
  logic         held_pe_l = 1'b0;
  bit           mon_en = 1'b0;
  int           vectors = 0;
  int           miscompares = 0;
  int           words_seen = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W), .SHIFT_DIRECTION("RIGHT")) dut_r (
    .clk(clk), .rst(rst), .si(si), .si_valid(si_valid), .clear(clear),
    .PO(po_r), .po_valid(pv_r), .parity_err(pe_r)
  );

  sipo_deserializer #(.WIDTH(W), .SHIFT_DIRECTION("LEFT")) dut_l (
    .clk(clk), .rst(rst), .si(si), .si_valid(si_valid), .clear(clear),
    .PO(po_l), .po_valid(pv_l), .parity_err(pe_l)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: a frame is the first FRAME accepted bits after
  // reset/clear; bit k of the stream is word bit k (RIGHT) or W-1-k (LEFT).
  task automatic model(input logic s, input logic v, input logic c, input logic r);
    exp_t er, el;
    int   ones;
    if (r) begin
      bits_q.delete();
      held_r = '0; held_l = '0; held_pe_r = 1'b0; held_pe_l = 1'b0;
    end else if (c) begin
      bits_q.delete();
    end else if (v) begin
      bits_q.push_back(s);
      if (bits_q.size() == FRAME) begin
        ones = 0;
        for (int i = 0; i < W; i++) begin
          er.word[i]       = bits_q[i];
          el.word[W-1-i]   = bits_q[i];
          ones += int'(bits_q[i]);
        end
`ifdef SIPO_DESERIALIZER_PARITY_EN
        ones += int'(bits_q[W]);
        er.perr = ((ones % 2) == 1);
`else
        er.perr = 1'b0;
`endif
        el.perr = er.perr;
        q_r.push_back(er);
        q_l.push_back(el);
        bits_q.delete();
      end
    end
  endtask

  task automatic step(input logic s, input logic v, input logic c, input logic r);
    si = s; si_valid = v; clear = c; rst = r;
    @(posedge clk);
    model(s, v, c, r);
    @(negedge clk);
    #1;
  endtask

  // Send one frame: data bits in the chosen order, optional idle gap after
  // bit index gap_at, then (parity build) the even-parity bit, optionally flipped.
  task automatic send_word(input logic [W-1:0] val, input bit lsb_first,
                           input int gap_at, input int gap_len, input bit flip);
    logic b;
    for (int i = 0; i < W; i++) begin
      b = lsb_first ? val[i] : val[W-1-i];
      step(b, 1'b1, 1'b0, 1'b0);
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      end
    end
`ifdef SIPO_DESERIALIZER_PARITY_EN
    step((^val) ^ flip, 1'b1, 1'b0, 1'b0);
`else
    if (flip) step(1'b0, 1'b0, 1'b0, 1'b0);
`endif
  endtask

  // Monitor: a pending expectation means this cycle must strobe; otherwise
  // outputs must be quiet and hold the last completed word.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (q_r.size() > 0) begin
        e = q_r.pop_front();
        check("right_valid", 64'(pv_r), 64'(1));
        check("right_po", 64'(po_r), 64'(e.word));
        check("right_perr", 64'(pe_r), 64'(e.perr));
        held_r = e.word; held_pe_r = e.perr;
        words_seen++;
        $display("word %0d right: PO=%02h perr=%b", words_seen, po_r, pe_r);
      end else begin
        check("right_idle_valid", 64'(pv_r), 64'(0));
        check("right_hold_po", 64'(po_r), 64'(held_r));
        check("right_hold_perr", 64'(pe_r), 64'(held_pe_r));
      end
      if (q_l.size() > 0) begin
        e = q_l.pop_front();
        check("left_valid", 64'(pv_l), 64'(1));
        check("left_po", 64'(po_l), 64'(e.word));
        check("left_perr", 64'(pe_l), 64'(e.perr));
        held_l = e.word; held_pe_l = e.perr;
        $display("word %0d left:  PO=%02h perr=%b", words_seen, po_l, pe_l);
      end else begin
        check("left_idle_valid", 64'(pv_l), 64'(0));
        check("left_hold_po", 64'(po_l), 64'(held_l));
        check("left_hold_perr", 64'(pe_l), 64'(held_pe_l));
      end
    end
  end

  initial begin
    step(1'b0, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);          // checked reset state
    step(1'b0, 1'b0, 1'b0, 1'b0);

    send_word(8'hA5, 1'b1, -1, 0, 1'b0);   // LSB-first, back to back bits
    send_word(8'hA5, 1'b0, 3, 3, 1'b0);    // MSB-first with a 3-cycle gap after bit 4
    step(1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);          // abort partial word
    send_word(8'h3C, 1'b1, -1, 0, 1'b0);

    send_word(8'h12, 1'b1, -1, 0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);          // reset mid-word
    send_word(8'hFF, 1'b1, -1, 0, 1'b0);

    send_word(8'h01, 1'b1, -1, 0, 1'b0);   // back to back words
    send_word(8'hFF, 1'b1, -1, 0, 1'b0);

    for (int i = 0; i < FRAME - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);          // clear on the final bit discards the word
    send_word(8'h5A, 1'b0, -1, 0, 1'b0);

    send_word(8'hA5, 1'b1, -1, 0, 1'b0);   // correct parity bit (parity build)
    send_word(8'hA5, 1'b1, -1, 0, 1'b1);   // flipped parity bit (parity build)

    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 199) == 0));
    end

    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("right_queue_drained", 64'(q_r.size()), 64'(0));
    check("left_queue_drained", 64'(q_l.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
